// File: rtl/wb_stage.sv
// wb_stage: EX->WB register, write-back select, GPIO output register, retire counter.
// Define WB_FORWARD_EN to forward the WB result onto the EX operand outputs.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_EX,
    input  logic             stall,
    input  logic             flush,
    input  logic             regwrite_EX,
    input  logic [1:0]       regsel_EX,
    input  logic             GPIO_we_EX,
    input  logic [4:0]       rd_EX,
    input  logic [4:0]       rs1_EX,
    input  logic [4:0]       rs2_EX,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic [XLEN-1:0]  alu_result_EX,
    input  logic [19:0]      imm_u_EX,
    input  logic [XLEN-1:0]  gpio_in,
    input  logic [XLEN-1:0]  gpio_wdata_EX,
    output logic             regwrite_WB,
    output logic [4:0]       rd_WB,
    output logic [XLEN-1:0]  writedata_WB,
    output logic [XLEN-1:0]  gpio_out,
    output logic [CNT_W-1:0] retired,
    output logic [XLEN-1:0]  fwd_rs1_data,
    output logic [XLEN-1:0]  fwd_rs2_data
);

    logic            accept;
    logic            bubble;
    logic            sel_wr;
    logic [XLEN-1:0] wb_sel;

    assign accept = valid_EX & ~stall & ~flush;
    assign bubble = flush | (~valid_EX & ~stall);

    // regsel 11 is a no-write encoding: value zero and write suppressed
    always_comb begin
        wb_sel = '0;
        sel_wr = 1'b0;
        unique case (regsel_EX)
            2'b00: begin
                wb_sel = gpio_in;
                sel_wr = 1'b1;
            end
            2'b01: begin
                wb_sel = XLEN'({imm_u_EX, 12'b0});
                sel_wr = 1'b1;
            end
            2'b10: begin
                wb_sel = alu_result_EX;
                sel_wr = 1'b1;
            end
            2'b11: begin
                wb_sel = '0;
                sel_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_WB  <= 1'b0;
            rd_WB        <= '0;
            writedata_WB <= '0;
        end else if (accept) begin
            regwrite_WB  <= regwrite_EX & (rd_EX != 5'd0) & sel_wr;
            rd_WB        <= rd_EX;
            writedata_WB <= wb_sel;
        end else if (bubble) begin
            regwrite_WB  <= 1'b0;
            rd_WB        <= '0;
            writedata_WB <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out <= '0;
        end else if (accept && GPIO_we_EX) begin
            gpio_out <= gpio_wdata_EX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (accept) begin
            retired <= retired + CNT_W'(1);
        end
    end

`ifdef WB_FORWARD_EN
    logic wb_live;

    assign wb_live = regwrite_WB & (rd_WB != 5'd0);

    assign fwd_rs1_data = (wb_live && rd_WB == rs1_EX) ? writedata_WB : rf_rs1_data;
    assign fwd_rs2_data = (wb_live && rd_WB == rs2_EX) ? writedata_WB : rf_rs2_data;
`else
    logic unused_idx;

    assign unused_idx   = ^{rs1_EX, rs2_EX};
    assign fwd_rs1_data = rf_rs1_data;
    assign fwd_rs2_data = rf_rs2_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a behavioural model.
// Counter built 8 bits wide so wrap-around is reachable in a short run.
module tb_wb_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_EX, stall, flush;
    logic             regwrite_EX, GPIO_we_EX;
    logic [1:0]       regsel_EX;
    logic [4:0]       rd_EX, rs1_EX, rs2_EX;
    logic [XLEN-1:0]  rf_rs1_data, rf_rs2_data;
    logic [XLEN-1:0]  alu_result_EX, gpio_in, gpio_wdata_EX;
    logic [19:0]      imm_u_EX;
    logic             regwrite_WB;
    logic [4:0]       rd_WB;
    logic [XLEN-1:0]  writedata_WB, gpio_out;
    logic [CNT_W-1:0] retired;
    logic [XLEN-1:0]  fwd_rs1_data, fwd_rs2_data;

    wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_EX(valid_EX), .stall(stall), .flush(flush),
        .regwrite_EX(regwrite_EX), .regsel_EX(regsel_EX),
        .GPIO_we_EX(GPIO_we_EX), .rd_EX(rd_EX),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .alu_result_EX(alu_result_EX), .imm_u_EX(imm_u_EX),
        .gpio_in(gpio_in), .gpio_wdata_EX(gpio_wdata_EX),
        .regwrite_WB(regwrite_WB), .rd_WB(rd_WB),
        .writedata_WB(writedata_WB), .gpio_out(gpio_out),
        .retired(retired),
        .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // model state: what WB must hold
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_wd, m_gpio;
    int          m_ret;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        m_rw = 0; m_rd = 0; m_wd = 0; m_gpio = 0; m_ret = 0;
    endtask

    function automatic logic [31:0] f_exp(input logic [4:0] rs,
                                          input logic [31:0] rf);
`ifdef WB_FORWARD_EN
        if (m_rw && m_rd != 0 && m_rd == rs) return m_wd;
`endif
        return rf;
    endfunction

    task automatic model_edge();
        logic acc;
        acc = valid_EX && !stall && !flush;
        if (acc) begin
            m_rd = rd_EX;
            case (regsel_EX)
                2'd0: m_wd = gpio_in;
                2'd1: m_wd = {12'b0, imm_u_EX} * 32'd4096;
                2'd2: m_wd = alu_result_EX;
                default: m_wd = 0;
            endcase
            m_rw = regwrite_EX && rd_EX != 0 && regsel_EX != 2'd3;
            if (GPIO_we_EX) m_gpio = gpio_wdata_EX;
            m_ret = (m_ret + 1) % 256;
        end else if (flush || !stall) begin
            m_rw = 0; m_rd = 0; m_wd = 0;
        end
    endtask

    task automatic compare_all();
        chk("regwrite_WB", 64'(regwrite_WB), 64'(m_rw));
        chk("rd_WB", 64'(rd_WB), 64'(m_rd));
        chk("writedata_WB", 64'(writedata_WB), 64'(m_wd));
        chk("gpio_out", 64'(gpio_out), 64'(m_gpio));
        chk("retired", 64'(retired), 64'(m_ret));
        chk("fwd_rs1", 64'(fwd_rs1_data), 64'(f_exp(rs1_EX, rf_rs1_data)));
        chk("fwd_rs2", 64'(fwd_rs2_data), 64'(f_exp(rs2_EX, rf_rs2_data)));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic s, input logic f,
                         input logic rw, input logic [1:0] sel,
                         input logic we, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [19:0] imm,
                         input logic [31:0] gin, input logic [31:0] gw);
        valid_EX = v; stall = s; flush = f;
        regwrite_EX = rw; regsel_EX = sel; GPIO_we_EX = we;
        rd_EX = rd; alu_result_EX = alu; imm_u_EX = imm;
        gpio_in = gin; gpio_wdata_EX = gw;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_rw"}, 64'(regwrite_WB), 64'd0);
        chk({nm, "_rd"}, 64'(rd_WB), 64'd0);
        chk({nm, "_wd"}, 64'(writedata_WB), 64'd0);
        chk({nm, "_gpio"}, 64'(gpio_out), 64'd0);
        chk({nm, "_ret"}, 64'(retired), 64'd0);
    endtask

    // asynchronous reset asserted between edges, released on a falling edge
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 0, 20'd0, 0, 0);
        rs1_EX = 0; rs2_EX = 0; rf_rs1_data = 0; rf_rs2_data = 0;
        model_clear();
        #1 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD x5 = 7
        drive(1, 0, 0, 1, 2'd2, 0, 5'd5, 32'h7, 20'd0, 0, 0);
        step();
        chk("add_rw", 64'(regwrite_WB), 64'd1);
        chk("add_rd", 64'(rd_WB), 64'd5);
        chk("add_wd", 64'(writedata_WB), 64'd7);
        chk("add_ret", 64'(retired), 64'd1);

        // LUI x3, then LUI x0
        drive(1, 0, 0, 1, 2'd1, 0, 5'd3, 32'h0, 20'hABCDE, 0, 0);
        step();
        chk("lui_wd", 64'(writedata_WB), 64'hABCDE000);
        chk("lui_rw", 64'(regwrite_WB), 64'd1);
        drive(1, 0, 0, 1, 2'd1, 0, 5'd0, 32'h0, 20'hABCDE, 0, 0);
        step();
        chk("lui_x0_rw", 64'(regwrite_WB), 64'd0);
        chk("lui_x0_ret", 64'(retired), 64'd3);

        // CSRRW: GPIO write and register write together
        drive(1, 0, 0, 1, 2'd0, 1, 5'd9, 32'h0, 20'd0, 32'h55, 32'h1234);
        step();
        chk("csr_gpio", 64'(gpio_out), 64'h1234);
        chk("csr_wd", 64'(writedata_WB), 64'h55);

        // stall+flush with a valid ADD is a bubble
        drive(1, 1, 1, 1, 2'd2, 1, 5'd6, 32'hDEAD, 20'd0, 0, 32'hBEEF);
        step();
        chk("sf_rw", 64'(regwrite_WB), 64'd0);
        chk("sf_gpio", 64'(gpio_out), 64'h1234);
        chk("sf_ret", 64'(retired), 64'd4);

        // load x7 = 0x99, then stall three cycles
        drive(1, 0, 0, 1, 2'd2, 0, 5'd7, 32'h99, 20'd0, 0, 0);
        step();
        drive(1, 1, 0, 1, 2'd2, 1, 5'd2, 32'h1, 20'd0, 0, 32'h7777);
        rs1_EX = 5'd7; rs2_EX = 5'd7; rf_rs1_data = 0; rf_rs2_data = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_wd", 64'(writedata_WB), 64'h99);
            chk("stall_rd", 64'(rd_WB), 64'd7);
        end
`ifdef WB_FORWARD_EN
        chk("fwd1_lit", 64'(fwd_rs1_data), 64'h99);
        chk("fwd2_lit", 64'(fwd_rs2_data), 64'h99);
`else
        chk("fwd1_lit", 64'(fwd_rs1_data), 64'h0);
        chk("fwd2_lit", 64'(fwd_rs2_data), 64'h0);
`endif

        // reset while stalled with a pending write
        mid_reset();
        step();
        check_zero("post_rst");

        // randomized stream
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 6) == 0, 1'($urandom),
                  2'($urandom), 1'($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 7)), $urandom, 20'($urandom),
                  $urandom, $urandom);
            rs1_EX = 5'($urandom_range(0, 7));
            rs2_EX = 5'($urandom_range(0, 7));
            rf_rs1_data = $urandom;
            rf_rs2_data = $urandom;
            if ($urandom_range(0, 499) == 0) mid_reset();
            step();
        end

        // counter wrap: run to all-ones, then one more accept
        drive(1, 0, 0, 0, 2'd3, 0, 5'd0, 0, 20'd0, 0, 0);
        for (int n = 0; n < 300 && m_ret != 255; n++) step();
        chk("ret_max", 64'(retired), 64'd255);
        step();
        chk("ret_wrap", 64'(retired), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

EX→WB pipeline stage of the three-stage RISC-V core, directly downstream of the control unit. Captures the EX-stage control bundle (regwrite, regsel, GPIO write enable) and datapath values, selects the register-file write-back value, owns the GPIO output register, and counts retired instructions. Optionally forwards the WB result back to EX operands.

## Interface
- XLEN, 32, datapath width
- CNT_W, 32, retired-instruction counter width
---
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_EX  in  1  EX holds a real instruction
- stall  in  1  hold WB state, accept nothing
- flush  in  1  replace EX instruction with a bubble
- regwrite_EX  in  1  control unit: instruction writes rd
- regsel_EX  in  2  control unit: write-back source select
- GPIO_we_EX  in  1  control unit: instruction writes GPIO out
- rd_EX  in  5  destination register
- rs1_EX, rs2_EX  in  5 each  source register indices
- rf_rs1_data, rf_rs2_data  in  XLEN each  register-file read data
- alu_result_EX  in  XLEN  ALU output
- imm_u_EX  in  20  U-type immediate
- gpio_in  in  XLEN  GPIO input port (CSR read source)
- gpio_wdata_EX  in  XLEN  GPIO write data (rs1 value)
- regwrite_WB  out  1  register-file write enable
- rd_WB  out  5  register-file write index
- writedata_WB  out  XLEN  register-file write data
- gpio_out  out  XLEN  GPIO output register
- retired  out  CNT_W  retired-instruction count
- fwd_rs1_data, fwd_rs2_data  out  XLEN each  EX operand values

## Operation
- Accept = valid_EX & ~stall & ~flush. flush wins over stall: bubble is written even if stall=1.
- On accept: rd_WB←rd_EX; regwrite_WB←regwrite_EX & (rd_EX≠0); writedata_WB←mux(regsel_EX).
- regsel: 00 gpio_in (sampled in EX cycle); 01 {imm_u_EX,12'b0}; 10 alu_result_EX; 11 all-zero, regwrite_WB forced 0.
- Bubble (flush, or ~valid_EX & ~stall): regwrite_WB←0, rd_WB←0, writedata_WB←0; gpio_out, retired unchanged.
- stall without flush: all WB registers, gpio_out, retired hold.
- gpio_out←gpio_wdata_EX on accept & GPIO_we_EX. GPIO write and register write in the same instruction both occur.
- retired increments by 1 on every accept (bubbles not counted); wraps 2^CNT_W−1 → 0.

## Timing
- Reset (async assert, sync-to-clk deassert externally): regwrite_WB=0, rd_WB=0, writedata_WB=0, gpio_out=0, retired=0. Reset mid-stall clears everything; no pending write survives.
- Latency: EX values visible on WB outputs and gpio_out one cycle after accept edge.
- Register file writes on the edge after regwrite_WB is seen; regwrite_WB is high for exactly one cycle per accepted writing instruction unless stall holds it (held value is rewritten, idempotent).
- fwd_* are combinational from current WB registers and EX indices; no added cycle.

## Configuration
- WB_FORWARD_EN defined: fwd_rsN_data = writedata_WB when regwrite_WB & rd_WB≠0 & rd_WB==rsN_EX, else rf_rsN_data. Both operands checked independently.
- Undefined: fwd_rsN_data = rf_rsN_data unconditionally; register file must provide write-before-read bypass.

## Test plan
- Reset with rst_n=0 mid-stream, clk running → all outputs 0 asynchronously, retired=0 after release.
- ADD x5 (regsel=10, alu_result=0x0000_0007, regwrite=1) → next cycle regwrite_WB=1, rd_WB=5, writedata_WB=7, retired=1.
- LUI x3 imm_u=0xABCDE, regsel=01 → writedata_WB=0xABCD_E000; rd_EX=0 variant → regwrite_WB=0, retired still increments.
- CSRRW: GPIO_we_EX=1, gpio_wdata=0x1234, regsel=00, gpio_in=0x55 → gpio_out=0x1234, writedata_WB=0x55 same cycle.
- stall=1 and flush=1 together with valid ADD → bubble: regwrite_WB=0, gpio_out and retired unchanged; stall alone → WB outputs held 3 cycles.
- WB_FORWARD_EN: WB holds x7=0x99, EX rs1=7, rs2=7, rf data=0 → both fwd outputs 0x99; macro off → both 0. retired preset to 0xFFFF_FFFF + accept → 0.
